// File: rtl/mod_dec_add_round_key_seq.sv
// Reverse-order AddRoundKey sequencer for the AES-256 inverse cipher: applies round keys NR..0 to a
// stream of state beats. Optional DEC_ARK_ZEROIZE_EN: key_idx 4'hF in IDLE wipes the key store.
module mod_dec_add_round_key_seq #(
    parameter int NR = 14,
    parameter int BW = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_wr,
    input  logic [3:0]       key_idx,
    input  logic [BW-1:0]    key_in,
    output logic             keys_loaded,
    output logic             key_err,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic             blk_first,
    input  logic [15:0][7:0] blk_in,
    output logic [15:0][7:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [3:0]       round,
    output logic             last
);
    localparam logic [3:0] NR4 = 4'(NR);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_reg;
    logic [3:0]      rc_reg;
    logic [NR:0]     mask_reg;
    logic [BW-1:0]   key_mem [0:NR];

    logic            accept;
    logic            wr_ok;
    logic            zero_req;
    logic [3:0]      key_sel;
    logic [BW-1:0]   key_cur;
    logic [15:0][7:0] o_next;

    assign keys_loaded = &mask_reg;
    assign blk_ready   = keys_loaded && (!o_valid || o_ready);
    assign accept      = blk_valid && blk_ready;

    // blk_first restarts the schedule at the top key, whatever the counter says
    assign key_sel = blk_first ? NR4 : rc_reg;
    assign key_cur = key_mem[key_sel];

    // Key writes are judged on the pre-edge state, so a same-cycle beat never blocks them
    assign wr_ok = key_wr && (state_reg == IDLE) && !o_valid && (key_idx <= NR4);

`ifdef DEC_ARK_ZEROIZE_EN
    assign zero_req = key_wr && (key_idx == 4'hF) && (state_reg == IDLE) && !o_valid;
`else
    assign zero_req = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_xor
            assign o_next[gi] = blk_in[gi] ^ key_cur[8*gi +: 8];
        end

        for (genvar gi = 0; gi <= NR; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    key_mem[gi]  <= '0;
                    mask_reg[gi] <= 1'b0;
                end else if (zero_req) begin
                    key_mem[gi]  <= '0;
                    mask_reg[gi] <= 1'b0;
                end else if (wr_ok && (key_idx == 4'(gi))) begin
                    key_mem[gi]  <= key_in;
                    mask_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            rc_reg    <= NR4;
            o         <= '0;
            o_valid   <= 1'b0;
            round     <= NR4;
            last      <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            key_err <= key_wr && !wr_ok && !zero_req;

            if (accept) begin
                o       <= o_next;
                o_valid <= 1'b1;
                round   <= key_sel;
                last    <= (key_sel == 4'd0);
                if (blk_first) begin
                    rc_reg    <= NR4 - 4'd1;
                    state_reg <= RUN;
                end else if (rc_reg == 4'd0) begin
                    rc_reg    <= NR4;
                    state_reg <= IDLE;
                end else begin
                    rc_reg    <= rc_reg - 4'd1;
                    state_reg <= RUN;
                end
            end else if (o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mod_dec_add_round_key_seq.sv
// Scoreboard bench for mod_dec_add_round_key_seq: directed steps, expected beats queued on accept.
module tb_mod_dec_add_round_key_seq;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_wr = 1'b0;
    logic [3:0]       key_idx = '0;
    logic [127:0]     key_in = '0;
    logic             keys_loaded;
    logic             key_err;
    logic             blk_valid = 1'b0;
    logic             blk_ready;
    logic             blk_first = 1'b0;
    logic [15:0][7:0] blk_in = '0;
    logic [15:0][7:0] o;
    logic             o_valid;
    logic             o_ready = 1'b0;
    logic [3:0]       round;
    logic             last;

    mod_dec_add_round_key_seq dut (
        .clk(clk), .rst(rst), .key_wr(key_wr), .key_idx(key_idx), .key_in(key_in),
        .keys_loaded(keys_loaded), .key_err(key_err), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .blk_first(blk_first), .blk_in(blk_in), .o(o),
        .o_valid(o_valid), .o_ready(o_ready), .round(round), .last(last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   r;
        logic         l;
    } exp_t;

    exp_t         sb[$];
    int           n_assert = 0;
    int           n_fail = 0;
    logic [127:0] m_key [0:14];
    logic [14:0]  m_mask;
    logic [3:0]   m_rc;
    bit           m_run;
    bit           m_ov;
    bit           m_kerr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_key[i] = '0;
        m_mask = '0;
        m_rc   = 4'd14;
        m_run  = 0;
        m_ov   = 0;
        m_kerr = 0;
        sb.delete();
    endtask

    function automatic logic [127:0] rep(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {16{b}};
    endfunction

    // One clock: drive, check the current outputs against the model, advance the model, clock.
    task automatic cycle(input bit v, input bit first, input logic [127:0] data, input bit ordy,
                         input bit kwr = 0, input logic [3:0] kidx = 0,
                         input logic [127:0] kin = '0);
        bit         exp_ready, accept, wr_ok, zero;
        logic [3:0] k;
        blk_valid = v; blk_first = first; blk_in = data; o_ready = ordy;
        key_wr = kwr; key_idx = kidx; key_in = kin;
        #1;
        exp_ready = (&m_mask) && (!m_ov || ordy);
        chk("blk_ready", blk_ready, exp_ready);
        chk("keys_loaded", keys_loaded, &m_mask);
        chk("key_err", key_err, m_kerr);
        chk("o_valid", o_valid, m_ov);
        if (m_ov && sb.size() > 0) begin
            chk("o", o, sb[0].d);
            chk("round", round, sb[0].r);
            chk("last", last, sb[0].l);
        end
        accept = v && exp_ready;
        wr_ok  = kwr && !m_run && !m_ov && (kidx <= 4'd14);
`ifdef DEC_ARK_ZEROIZE_EN
        zero   = kwr && (kidx == 4'hF) && !m_run && !m_ov;
`else
        zero   = 0;
`endif
        m_kerr = kwr && !wr_ok && !zero;
        if (m_ov && ordy && sb.size() > 0) void'(sb.pop_front());
        if (accept) begin
            k = first ? 4'd14 : m_rc;
            sb.push_back('{d: data ^ m_key[k], r: k, l: (k == 4'd0)});
            if (first) begin
                m_rc = 4'd13; m_run = 1;
            end else if (m_rc == 4'd0) begin
                m_rc = 4'd14; m_run = 0;
            end else begin
                m_rc = m_rc - 4'd1; m_run = 1;
            end
        end
        m_ov = accept || (m_ov && !ordy);
        if (wr_ok) begin
            m_key[kidx]  = kin;
            m_mask[kidx] = 1'b1;
        end
        if (zero) begin
            for (int i = 0; i < 15; i++) m_key[i] = '0;
            m_mask = '0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_keys();
        for (int n = 0; n < 15; n++) cycle(1, 0, '0, 1, 1, 4'(n), rep(n));
    endtask

    task automatic check_reset_outputs();
        chk("rst_o", o, '0);
        chk("rst_round", round, 4'd14);
        chk("rst_last", last, 1'b0);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_key_err", key_err, 1'b0);
        chk("rst_keys_loaded", keys_loaded, 1'b0);
        chk("rst_blk_ready", blk_ready, 1'b0);
    endtask

    initial begin
        logic [127:0] d;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Beats stall while keys are missing; a beat is offered during the whole load
        cycle(1, 1, '0, 1);
        load_keys();
        cycle(0, 0, '0, 1);

        // Full block of zero data: o = {16{round}}
        for (int i = 0; i < 15; i++) cycle(1, i == 0, '0, 1);
        repeat (2) cycle(0, 0, '0, 1);

        // Random block with a 3-cycle downstream stall, then back-to-back beats
        for (int i = 0; i < 15; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i == 2) repeat (3) cycle(1, 0, d, 0);
            cycle(1, i == 0, d, 1);
        end
        repeat (2) cycle(0, 0, '0, 1);

        // Mid-block key write rejected, then blk_first abort and a full block proving key[3] kept
        for (int i = 0; i < 7; i++) cycle(1, i == 0, '0, 1);
        cycle(0, 0, '0, 1, 1, 4'd3, '1);
        for (int i = 0; i < 15; i++) cycle(1, i == 0, '0, 1);
        repeat (2) cycle(0, 0, '0, 1);

        // Key rewrite in IDLE alongside an accepted first beat: both take effect
        cycle(1, 1, '0, 1, 1, 4'd5, rep(8'hA5));
        for (int i = 0; i < 14; i++) cycle(1, 0, '0, 1);
        repeat (2) cycle(0, 0, '0, 1);

        // Asynchronous reset partway through a block
        for (int i = 0; i < 10; i++) cycle(1, i == 0, '0, 1);
        #2 rst = 1'b1;
        blk_valid = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle(1, 1, '0, 1);
        load_keys();
        for (int i = 0; i < 15; i++) cycle(1, i == 0, '0, 1);
        repeat (2) cycle(0, 0, '0, 1);

        // Index 4'hF in IDLE: zeroize when enabled, otherwise rejected
        cycle(0, 0, '0, 1, 1, 4'hF, '1);
        repeat (2) cycle(1, 1, '0, 1);
        repeat (2) cycle(0, 0, '0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mod_dec_add_round_key_seq.md
Name: mod_dec_add_round_key_seq

Overview:
Decryption-side AddRoundKey sequencer for the AES-256 inverse cipher.
- Holds the 15 round keys, written once in encryption order (index 0..14).
- Applies them to the state stream in reverse order (14 down to 0), one key per accepted beat.
- Sits between the inverse-round datapath and the key-expansion writer; registered output with valid/ready handshake.

Parameters:
NR, 14, number of cipher rounds; key store depth is NR+1, key index width is 4 bits.
BW, 128, state/key width in bits; byte i occupies bits 8*i+7:8*i.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
key_wr  input  1  key store write strobe
key_idx  input  4  round key index for write
key_in  input  128  round key value
keys_loaded  output  1  high when all NR+1 key slots written since reset/clear
key_err  output  1  one-cycle pulse: key write rejected
blk_valid  input  1  input state beat valid
blk_ready  output  1  beat accepted when blk_valid && blk_ready
blk_first  input  1  qualifies beat as first round of a new block
blk_in  input  [15:0][7:0]  input state
o  output  [15:0][7:0]  state XOR selected round key
o_valid  output  1  output beat valid
o_ready  input  1  downstream accepts o
round  output  4  key index applied to current o
last  output  1  high with o_valid when round==0

Behaviour:
- Reset (async, any time incl. mid-block):
  - o=0, o_valid=0, round=NR, last=0, key_err=0.
  - Valid mask cleared, keys_loaded=0, key store zeroed.
  - Round counter rc=NR, FSM to IDLE.
- FSM IDLE (rc==NR, no block in progress):
  - An accepted beat with rc==NR goes to RUN.
- FSM RUN:
  - Each accepted beat uses key[rc], then rc decrements.
  - Beat using key 0 sets rc=NR and returns to IDLE (wrap).
- blk_first on an accepted beat forces key NR regardless of rc; next rc=NR-1, state RUN (aborts any partial block).
- Key writes:
  - Accepted only in IDLE with o_valid=0 and key_idx<=NR: store[key_idx]<=key_in, mask bit set.
  - Any other key_wr is ignored and pulses key_err the next cycle.
  - Rewriting a slot is allowed and keeps its mask bit set.
- keys_loaded = AND of all NR+1 mask bits.
- Handshake:
  - blk_ready = keys_loaded && state allows (not gated by key_wr) && (!o_valid || o_ready).
  - Single-entry output register, no combinational path blk_in->o.
  - Latency is 1 cycle: beat accepted at edge n appears on o/o_valid after edge n.
  - o, round and last hold stable while o_valid && !o_ready.
  - Simultaneous o_ready and new accept: register reloads, o_valid stays 1, full throughput of 1 beat/cycle.
- Arithmetic: o[i] = blk_in[i] ^ key[rc][8*i +: 8], i=0..15; pure XOR, no carries.
- blk_valid while keys_loaded=0: blk_ready=0, beat stalls, no state change.
- key_wr and accepted beat in the same cycle: the beat wins, and the write is rejected only if the FSM is not IDLE after the check on the current state. Write check uses pre-edge state.

Optional Feature:
- Macro DEC_ARK_ZEROIZE_EN.
- Defined: key_wr with key_idx==4'hF while IDLE and o_valid=0 clears all key slots to 0 and clears the mask.
  - keys_loaded drops the next cycle.
  - key_err is not pulsed.
- Not defined: key_idx==4'hF is an out-of-range write: ignored, key_err pulses.

Test Plan:
- Reset, write key[n]={16{n[7:0]}} for n=0..14 -> keys_loaded rises after the 15th write; before that, blk_valid=1 gives blk_ready=0.
- blk_in all 8'h00 with blk_first, o_ready=1 -> one cycle later o={16{8'h0E}}, round=14, last=0; 14 further beats of 8'h00 give rounds 13..0, o={16{round}}, last=1 on the final beat, then rc=14, IDLE.
- o_ready=0 for 3 cycles with o_valid=1 -> o, round, blk_ready=0 held; raise o_ready with new beat valid -> back-to-back beats, no bubble.
- Mid-block (round 7 pending): key_wr idx 3 -> key_err pulse, key[3] unchanged; beat with blk_first -> round=14 applied.
- Assert rst during RUN at round 5 -> all outputs reset, keys_loaded=0; subsequent beat stalls until all keys reloaded.
- With DEC_ARK_ZEROIZE_EN: key_wr idx 4'hF in IDLE -> keys_loaded=0, no key_err; without the macro -> key_err=1, keys_loaded stays 1.
